// File: rtl/fib_rec.sv
// fib_rec: n-th term of x(k) = x(k-1) + x(k-2) from caller-supplied seeds,
// one addition per cycle behind the ap_ block-level handshake.
module fib_rec #(
    parameter int WIDTH    = 32,
    parameter int NWIDTH   = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [NWIDTH-1:0] ap_n,
    input  logic [WIDTH-1:0]  ap_x0,
    input  logic [WIDTH-1:0]  ap_x1,
    output logic [WIDTH-1:0]  ap_return,
    output logic              ap_overflow
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CHECK = 2'd1;
    localparam logic [1:0] LOOP  = 2'd2;

    logic [1:0]        state;
    logic [NWIDTH-1:0] cnt;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic              ovf;
    logic [WIDTH:0]    sum;

    // The extra top bit of sum is the carry out that marks an overflowing addition.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign ap_idle = (state == IDLE);

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state       <= IDLE;
            ap_done     <= 1'b0;
            ap_ready    <= 1'b1;
            ap_return   <= '0;
            ap_overflow <= 1'b0;
            cnt         <= '0;
            a           <= '0;
            b           <= '0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        cnt      <= ap_n;
                        a        <= ap_x0;
                        b        <= ap_x1;
                        ovf      <= 1'b0;
                        ap_ready <= 1'b0;
                        ap_done  <= 1'b0;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (cnt == '0) begin
                        ap_return   <= a;
                        ap_overflow <= 1'b0;
                        ap_ready    <= 1'b1;
                        ap_done     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= LOOP;
                    end
                end
                LOOP: begin
                    // cnt never goes below 1 here, so the maximum index cannot wrap it.
                    if (cnt > NWIDTH'(1)) begin
                        a   <= b;
                        cnt <= cnt - NWIDTH'(1);
                        if (sum[WIDTH]) begin
                            ovf <= 1'b1;
                            if (SATURATE) begin
                                b <= '1;
                            end else begin
                                b <= sum[WIDTH-1:0];
                            end
                        end else begin
                            b <= sum[WIDTH-1:0];
                        end
                    end else begin
                        ap_return   <= b;
                        ap_overflow <= ovf;
                        ap_ready    <= 1'b1;
                        ap_done     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fib_rec.md
Name: fib_rec

Overview:
- Parametrised successor of the team's scalar Fibonacci block.
- Computes the n-th term of the two-term recurrence x(k) = x(k-1) + x(k-2), with caller-supplied seeds x(0) and x(1). This covers Fibonacci, Lucas and similar sequences.
- Datapath width and iteration-count width are configurable. Overflow handling is selectable: wrap or saturate. A sticky overflow flag is reported.
- Sits behind the standard ap_ block-level handshake. Does one addition per cycle, instead of a multi-state loop body.

Parameters:
- WIDTH, 32, datapath width of seeds, terms and result.
- NWIDTH, 32, width of the term index ap_n.
- SATURATE, 0, overflow mode: 0 = sum wraps modulo 2^WIDTH; 1 = sum clamps to 2^WIDTH-1.

Ports:
- ap_clk  in  1  clock. All logic on the rising edge.
- ap_rst  in  1  reset, synchronous, active-high.
- ap_start  in  1  request. Sampled only in IDLE.
- ap_done  out  1  registered. Set on completion; cleared when the next start is accepted.
- ap_idle  out  1  combinational, equals (state == IDLE).
- ap_ready  out  1  registered. 1 when able to accept a start; 0 while busy.
- ap_n  in  NWIDTH  index of the requested term, unsigned.
- ap_x0  in  WIDTH  seed x(0).
- ap_x1  in  WIDTH  seed x(1).
- ap_return  out  WIDTH  registered result x(n). Holds until the next completion.
- ap_overflow  out  1  registered. 1 if any addition for the last result exceeded 2^WIDTH-1.

Behaviour:
- Decided: one clock, ap_clk. Reset ap_rst is synchronous and active-high.
- Reset values:
  - state = IDLE, ap_done = 0, ap_ready = 1, ap_return = 0, ap_overflow = 0.
  - Internal regs: cnt = 0, a = 0, b = 0, ovf = 0.
- Reset mid-operation aborts the computation. No done pulse is produced.
- Internal regs: cnt (NWIDTH), a and b (WIDTH), ovf (1).
- State encoding: IDLE = 0, CHECK = 1, LOOP = 2. Any other encoding returns to IDLE.
- IDLE:
  - If ap_start: latch cnt <= ap_n, a <= ap_x0, b <= ap_x1, ovf <= 0; set ap_ready <= 0, ap_done <= 0; go to CHECK.
  - Inputs are sampled only on this accepting edge. Later changes are ignored.
- CHECK:
  - If cnt == 0: ap_return <= a, ap_overflow <= 0, ap_ready <= 1, ap_done <= 1; go to IDLE.
  - Else go to LOOP.
- LOOP, when cnt > 1:
  - Form sum = a + b at WIDTH+1 bits.
  - Update a <= b and cnt <= cnt - 1.
  - If sum[WIDTH] is set: ovf <= 1, and b <= all-ones when SATURATE = 1, else b <= sum[WIDTH-1:0].
  - If sum[WIDTH] is clear: b <= sum[WIDTH-1:0].
  - Stay in LOOP.
- LOOP, when cnt == 1: ap_return <= b, ap_overflow <= ovf, ap_ready <= 1, ap_done <= 1; go to IDLE.
- Latency, counted from the accepting edge to the edge that sets ap_done:
  - n = 0: 2 edges.
  - n >= 1: n + 2 edges.
- ap_start during CHECK or LOOP is ignored and not queued.
- Back-to-back operation: if ap_start is held high, a new start is accepted on the first IDLE edge after completion, one edge after ap_done rises. ap_done and ap_ready then drop on that edge.
- ap_done and ap_ready are level signals, not single-cycle pulses.
- Overflow is sticky across iterations.
- Saturation stays at all-ones, because later sums also saturate.
- In wrap mode the flag is still reported.
- Seeds are never checked. x0 = x1 = all-ones with n = 1 returns all-ones and ap_overflow = 0.
- The maximum index 2^NWIDTH - 1 must complete without the counter wrapping. cnt only decrements while cnt > 1.

Test Plan:
- Fibonacci, WIDTH = 32, x0 = 0, x1 = 1, n = 10 -> ap_return = 55, ap_overflow = 0. ap_done rises 12 edges after the accepting edge. ap_ready is 0 throughout.
- Boundary indices, same seeds: n = 0 -> 0 after 2 edges; n = 1 -> 1 after 3 edges; n = 2 -> 1.
- Overflow, WIDTH = 32:
  - n = 47 -> 2971215073, ap_overflow = 0.
  - n = 48 -> SATURATE = 0 gives 512559680; SATURATE = 1 gives 4294967295. ap_overflow = 1 in both modes.
- Overflow, WIDTH = 8:
  - n = 13 -> 233, ap_overflow = 0.
  - n = 14 -> 121 in wrap mode, 255 in saturate mode, ap_overflow = 1.
- Lucas seeds x0 = 2, x1 = 1, n = 5 -> 11.
  - Toggle ap_start and change ap_n, ap_x0, ap_x1 during LOOP: result still 11, no extra start.
  - Hold ap_start high: a second run (n = 5) is accepted on the edge after done.
- Assert ap_rst for 1 cycle mid-LOOP, with n = 20:
  - Next cycle: ap_idle = 1, ap_ready = 1, ap_done = 0, ap_return = 0, ap_overflow = 0.
  - Restart with n = 20 -> 6765.
